// File: rtl/btree_noc_pkg.sv
// Shared BTree NoC definitions: arbiter state encoding, default flit width
// and a constant-sizing helper used by the switch blocks.
package btree_noc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int FLIT_W = DATA_W + ADDR_W;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/btree_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// searching upward with wrap-around.
module rr_pick
  import btree_noc_pkg::*;
#(
  parameter int NumIn = 3,
  parameter int IdxW  = clog2(NumIn)
) (
  input  logic [NumIn-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [NumIn-1:0] grant,
  output logic [IdxW-1:0]  idx,
  output logic             any
);

  int              cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    any      = 1'b0;
    grant    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NumIn; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NumIn) cand = cand - NumIn;
      cand_idx = IdxW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant           = '0;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btree_link_arbiter.sv
// Output-link arbiter for one BTree switch port: round-robin grants bounded
// by a burst limit, feeding a registered valid/ready output stage.
module btree_link_arbiter
  import btree_noc_pkg::*;
#(
  parameter int DataWidth = FLIT_W,
  parameter int NumIn     = 3,
  parameter int MaxBurst  = 4
) (
  input  logic                       i_sclk,
  input  logic                       i_reset,
  input  logic [NumIn*DataWidth-1:0] i_data,
  input  logic [NumIn-1:0]           i_data_valid,
  output logic [NumIn-1:0]           o_data_ready,
  output logic [DataWidth-1:0]       o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic [NumIn-1:0]           o_grant
);

  localparam int IdxW = clog2(NumIn);
  localparam int CntW = clog2(MaxBurst + 1);
  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(NumIn - 1);
  localparam logic [CntW-1:0] LAST_CNT = CntW'(MaxBurst - 1);

  arb_state_e           state_reg;
  logic [IdxW-1:0]      gnt_reg;
  logic [IdxW-1:0]      rr_ptr_reg;
  logic [CntW-1:0]      burst_cnt_reg;
  logic [DataWidth-1:0] o_data_reg;
  logic                 o_data_valid_reg;
  logic [NumIn-1:0]     o_grant_reg;

  logic [DataWidth-1:0] in_word [NumIn];
  logic [NumIn-1:0]     pick_onehot;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 granted;
  logic                 out_rdy;
  logic                 gnt_valid;
  logic                 in_xfer;
  logic                 release_now;

  assign granted   = (state_reg == ARB_GRANT);
  assign out_rdy   = !o_data_valid_reg || i_data_ready;
  assign gnt_valid = i_data_valid[gnt_reg];
  assign in_xfer   = granted && gnt_valid && out_rdy;
  // A granted source dropping valid releases even while the output is stalled.
  assign release_now = granted && (!gnt_valid || (in_xfer && burst_cnt_reg == LAST_CNT));

  genvar gi;
  generate
    for (gi = 0; gi < NumIn; gi++) begin : g_in
      assign in_word[gi]      = i_data[gi*DataWidth +: DataWidth];
      assign o_data_ready[gi] = granted && (gnt_reg == IdxW'(gi)) && out_rdy;
    end
  endgenerate

  rr_pick #(
    .NumIn(NumIn),
    .IdxW (IdxW)
  ) u_pick (
    .req  (i_data_valid),
    .ptr  (rr_ptr_reg),
    .grant(pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      state_reg        <= ARB_IDLE;
      gnt_reg          <= '0;
      rr_ptr_reg       <= '0;
      burst_cnt_reg    <= '0;
      o_data_reg       <= '0;
      o_data_valid_reg <= 1'b0;
      o_grant_reg      <= '0;
    end else begin
      if (in_xfer) begin
        o_data_reg       <= in_word[gnt_reg];
        o_data_valid_reg <= 1'b1;
      end else if (i_data_ready) begin
        o_data_valid_reg <= 1'b0;
      end

      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            state_reg     <= ARB_GRANT;
            gnt_reg       <= pick_idx;
            o_grant_reg   <= pick_onehot;
            burst_cnt_reg <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            state_reg   <= ARB_IDLE;
            o_grant_reg <= '0;
            rr_ptr_reg  <= (gnt_reg == LAST_IDX) ? '0 : gnt_reg + 1'b1;
          end else if (in_xfer) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign o_data       = o_data_reg;
  assign o_data_valid = o_data_valid_reg;
  assign o_grant      = o_grant_reg;

endmodule
